// File: rtl/leg_mul_arbiter.sv
// leg_mul_arbiter: round-robin arbiter/sequencer for two requesters
// sharing one combinational LEG 8x8 MUL unit (low/high byte by opcode).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready         request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_op  operands and op (0 lo, 1 hi, 2 wide, 3 rsvd)
//   respN_valid, respN_data  one-cycle result pulse and held result
//   mul_a, mul_b, mul_op     drive to the shared MUL unit
//   mul_result               MUL unit output, same cycle
module leg_mul_arbiter #(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [1:0]  req0_op,
  output logic        resp0_valid,
  output logic [15:0] resp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [1:0]  req1_op,
  output logic        resp1_valid,
  output logic [15:0] resp1_data,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic [7:0]  mul_op,
  input  logic [7:0]  mul_result
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_LO,
    ISSUE_HI,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        gid;
  logic [7:0]  lat_a;
  logic [7:0]  lat_b;
  logic [1:0]  lat_op;
  logic [7:0]  lo_reg;
  logic [7:0]  hi_reg;
  logic        grant1;
  logic        accept;

  // Requester 1 wins when alone, or on a tie when 0 was served last.
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);
  assign accept = req0_ready | req1_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = ISSUE_LO;
      ISSUE_LO: state_nxt = (lat_op == 2'd2) ? ISSUE_HI : RESP;
      ISSUE_HI: state_nxt = RESP;
      RESP:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    mul_a       = 8'd0;
    mul_b       = 8'd0;
    mul_op      = 8'd0;
    unique case (state)
      IDLE: begin
        // Gated by rst so a request never lands in the reset cycle.
        req0_ready = ~rst & req0_valid & ~grant1;
        req1_ready = ~rst & grant1;
      end
      ISSUE_LO: begin
        mul_a = lat_a;
        mul_b = lat_b;
        case (lat_op)
          2'd1:    mul_op = 8'd1;
          2'd3:    mul_op = 8'd7;
          default: mul_op = 8'd0;
        endcase
      end
      ISSUE_HI: begin
        mul_a  = lat_a;
        mul_b  = lat_b;
        mul_op = 8'd1;
      end
      RESP: begin
        resp0_valid = ~gid;
        resp1_valid = gid;
      end
    endcase
  end

  // Datapath: latched request, partial products, held responses.
  // Response registers load on entry to RESP so they are valid
  // for the whole pulse and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      gid        <= 1'b0;
      lat_a      <= 8'd0;
      lat_b      <= 8'd0;
      lat_op     <= 2'd0;
      lo_reg     <= 8'd0;
      hi_reg     <= 8'd0;
      resp0_data <= 16'd0;
      resp1_data <= 16'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            gid        <= grant1;
            last_grant <= grant1;
            lat_a      <= grant1 ? req1_a  : req0_a;
            lat_b      <= grant1 ? req1_b  : req0_b;
            lat_op     <= grant1 ? req1_op : req0_op;
          end
        end
        ISSUE_LO: begin
          lo_reg <= mul_result;
          if (lat_op != 2'd2) begin
            if (gid) resp1_data <= {8'h00, mul_result};
            else     resp0_data <= {8'h00, mul_result};
          end
        end
        ISSUE_HI: begin
          hi_reg <= mul_result;
          if (gid) resp1_data <= {mul_result, lo_reg};
          else     resp0_data <= {mul_result, lo_reg};
        end
        RESP: ;
      endcase
    end
  end

endmodule

// File: doc/leg_mul_arbiter.md
# leg_mul_arbiter

Two-requester arbiter and sequencer for the LEG 8-bit multiply ALU unit (low-byte/high-byte product selected by opcode). It accepts multiply requests from two masters, such as the LEG core and a coprocessor/DMA port, and grants them round-robin. It drives the shared unit's operand and opcode inputs for one or two cycles and returns an 8- or 16-bit product. The block sits between the requesters and the single MUL unit instance, which is purely combinational.

## Interface
- UUID, 0, instance identifier (unused in logic)
- NAME, "", instance name (unused in logic)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_a, req0_b  in  8 each  requester 0 operands
- req0_op  in  2  0 = low byte, 1 = high byte, 2 = wide 16-bit, 3 = reserved
- resp0_valid  out  1  one-cycle pulse, result for requester 0
- resp0_data  out  16  result for requester 0
- req1_valid, req1_ready, req1_a, req1_b, req1_op, resp1_valid, resp1_data: same as requester 0, for requester 1
- mul_a, mul_b  out  8 each  to MUL unit Input_1/Input_2
- mul_op  out  8  to MUL unit Opcode (0 = low, 1 = high, 2–7 yield 0)
- mul_result  in  8  MUL unit Output, combinational in the same cycle

## Operation
- State machine states: IDLE, ISSUE_LO, ISSUE_HI, RESP.
- **IDLE.** Grant selection:
  - Only one valid: that requester is granted.
  - Both valid: the requester not served last is granted.
  - req_ready is high only for the granted requester, and only in IDLE. It may depend combinationally on valid.
- **On accept (valid & ready):**
  - Latch a, b, op and the grant id.
  - Update last_grant.
  - Go to ISSUE_LO.
- **ISSUE_LO:** drive mul_a/mul_b with the latched operands.
  - mul_op = 0 for op 0 and op 2.
  - mul_op = 1 for op 1.
  - mul_op = 7 for op 3.
  - Capture mul_result into lo_reg at the clock edge.
  - Next state is ISSUE_HI if op = 2, else RESP.
- **ISSUE_HI:** drive the same operands with mul_op = 1, capture into hi_reg, go to RESP.
- **RESP:** assert resp_valid of the granted requester for exactly one cycle, then return to IDLE.
  - resp_data = {8'h00, lo_reg} for op 0, 1, 3.
  - resp_data = {hi_reg, lo_reg} for op 2.
- There is no response back-pressure. Requesters must sample data on resp_valid.
- resp_data holds its last value between pulses. The non-granted requester's resp_data is unchanged.
- Outside ISSUE_LO and ISSUE_HI, mul_a, mul_b and mul_op are driven to 0.
- Arithmetic is unsigned 8×8→16. The unit supplies the low and high bytes. The block does no arithmetic itself.

## Timing
- **Reset values:**
  - state = IDLE, last_grant = 1, so requester 0 wins the first tie.
  - All req_ready and resp_valid = 0.
  - resp0_data = resp1_data = 0.
  - mul_a = mul_b = mul_op = 0.
  - lo_reg = hi_reg = 0.
- **Latency:** accept in cycle N.
  - Narrow ops (0/1/3): resp_valid in cycle N+2.
  - Wide op (2): resp_valid in cycle N+3.
- **Throughput:** next accept no earlier than N+3 (narrow) or N+4 (wide). RESP does not accept.
- **Simultaneous valid in IDLE:** strict alternation while both stay valid, giving the sequence 0,1,0,1…
- **Requester dropping valid before ready:** no effect, and no request is latched.
- **Operand changes after accept:** ignored, because latched copies are used.
- **Reset in any state:** the in-flight request is dropped, no resp_valid is produced, and the block is in IDLE on the next cycle.
- **Reset in the same cycle as valid:** reset wins and the request is not accepted.

## Test plan
- **Narrow low:** req0 a=0x0F, b=0x11, op=0 → req0_ready in cycle N; mul_op=0 in N+1; resp0_valid in N+2 with resp0_data=0x00FF.
- **Wide:** req1 a=0xFF, b=0xFF, op=2 → mul_op=0 in N+1, mul_op=1 in N+2; resp1_valid in N+3 with resp1_data=0xFE01.
- **High only and reserved op:**
  - req0 a=0x80, b=0x04, op=1 → resp0_data=0x0002.
  - op=3 with any operands → resp0_data=0x0000 and mul_op=7 during issue.
- **Contention:** both requesters hold valid with 3 narrow requests each → grants alternate 0,1,0,1,0,1. No response goes to the wrong port. resp_valid never occurs on both ports in the same cycle.
- **Reset mid-operation:** assert rst during ISSUE_HI of a wide request → no resp_valid; all outputs are at reset values the next cycle; a fresh req0 is then served with normal latency.
- **Idle bus:** no requests for 10 cycles → mul_a = mul_b = mul_op = 0 and all ready/resp_valid signals stay low.
